// File: rtl/mantissa_div_if.sv
// Bundle of request/result signals for the sequential mantissa divider.
//
// Handshake: the master holds a_in/b_in stable and raises start for one or
// more cycles; a request is taken on any rising edge where busy=0 (including
// the cycle done=1). done is a one-cycle pulse; q/rem/dz (and sticky) stay
// valid from that pulse until the next request is taken.
//
// Signals
//   start        master -> slave  request
//   a_in, b_in   master -> slave  normalized dividend / divisor mantissas
//   busy         slave -> master  iteration in progress
//   done         slave -> master  one-cycle result-valid pulse
//   q            slave -> master  quotient, q[QW-1] has weight 2^0
//   rem          slave -> master  final partial remainder (after last shift)
//   dz           slave -> master  divide-by-zero flag
//   sticky       slave -> master  |rem, only with MANT_DIV_STICKY_EN
//
// Build option: MANT_DIV_STICKY_EN adds the sticky signal.
interface mantissa_div_if #(
  parameter int MW = 24,
  parameter int QW = MW + 2
);
  logic          start;
  logic [MW-1:0] a_in;
  logic [MW-1:0] b_in;
  logic          busy;
  logic          done;
  logic [QW-1:0] q;
  logic [MW:0]   rem;
  logic          dz;
`ifdef MANT_DIV_STICKY_EN
  logic          sticky;

  modport master (output start, a_in, b_in,
                  input  busy, done, q, rem, dz, sticky);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, q, rem, dz, sticky);
`else
  modport master (output start, a_in, b_in,
                  input  busy, done, q, rem, dz);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, q, rem, dz);
`endif
endinterface

// File: rtl/mantissa_div_seq.sv
// Sequential radix-2 restoring divider for normalized FP mantissas.
// Produces QW quotient bits (integer bit, fraction, guard/round) one per
// clock, MSB first, plus the final partial remainder and a divide-by-zero
// flag. Sits between operand unpack and round/normalize in the FP divide path.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   bus        mantissa_div_if.slave (start, a_in, b_in, busy, done, q, rem,
//              dz, and sticky when MANT_DIV_STICKY_EN is defined)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Build option: MANT_DIV_STICKY_EN adds a registered sticky = |rem output.
// Without it, downstream rounding derives sticky from rem.
module mantissa_div_seq #(
  parameter int MW = 24,
  parameter int QW = MW + 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mantissa_div_if.slave  bus,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          accept;
  logic [MW:0]   r_q;      // partial remainder, one bit wider than b
  logic [MW-1:0] b_q;
  logic [CW-1:0] cnt_q;    // index of the quotient bit being produced
  logic [QW-1:0] q_q;
  logic [MW:0]   rem_q;
  logic          dz_q;
  logic [MW+1:0] diff;
  logic          borrow;
  logic [MW:0]   r_next;
  logic          unused_diff_bit;

  // A request is taken whenever no iteration is running; DONE counts as idle.
  always_comb begin
    accept = bus.start && (state_q != RUN);
  end

  // Trial subtract: the top bit of the (MW+2)-bit difference is the borrow.
  // For in-range operands R < 2B, so a successful difference always fits in
  // MW bits and the shifted value fits back into MW+1.
  always_comb begin
    diff   = {1'b0, r_q} - {2'b00, b_q};
    borrow = diff[MW+1];
    r_next = borrow ? {r_q[MW-1:0], 1'b0} : {diff[MW-1:0], 1'b0};
  end

  assign unused_diff_bit = diff[MW];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start)             state_d = (bus.b_in == '0) ? DONE : RUN;
        else if (state_q == DONE)  state_d = IDLE;
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy  = (state_q == RUN);
    bus.done  = (state_q == DONE);
    dbg_state = state_q;
  end

  // Datapath. Results are cleared when a request is taken, so quotient bits
  // below the current index read as zero while iterating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      r_q   <= {1'b0, bus.a_in};
      b_q   <= bus.b_in;
      cnt_q <= CW'(QW - 1);
      rem_q <= '0;
      if (bus.b_in == '0) begin
        q_q  <= '1;
        dz_q <= 1'b1;
      end else begin
        q_q  <= '0;
        dz_q <= 1'b0;
      end
    end else if (state_q == RUN) begin
      q_q[cnt_q] <= ~borrow;
      r_q        <= r_next;
      if (cnt_q == '0) rem_q <= r_next;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.q   = q_q;
  assign bus.rem = rem_q;
  assign bus.dz  = dz_q;

`ifdef MANT_DIV_STICKY_EN
  logic sticky_q;

  // Registered together with the last remainder; a zero divisor leaves it 0.
  always_ff @(posedge clk) begin
    if (!rst_n)                                sticky_q <= 1'b0;
    else if (accept)                           sticky_q <= 1'b0;
    else if ((state_q == RUN) && (cnt_q == '0)) sticky_q <= |r_next;
  end

  assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_mantissa_div_seq.sv
// Directed bench for mantissa_div_seq (MW=24, QW=26). Inputs are driven on
// the falling edge and outputs sampled there too. "Cycle 1" is the cycle
// right after the edge that takes a request.
module tb_mantissa_div_seq;

  localparam int MW  = 24;
  localparam int QW  = 26;
  localparam int LAT = QW + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;

  mantissa_div_if #(.MW(MW), .QW(QW)) bus ();

  mantissa_div_seq #(.MW(MW), .QW(QW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Directed vectors with hand-computed q = floor(a*2^25/b), rem = 2*(a*2^25 - q*b)
  localparam int NV = 6;
  logic [MW-1:0] va [NV] = '{24'h800000, 24'hC00000, 24'h800000,
                             24'hFFFFFF, 24'h800000, 24'hFFFFFF};
  logic [MW-1:0] vb [NV] = '{24'h800000, 24'h800000, 24'hC00000,
                             24'h800000, 24'hFFFFFF, 24'hFFFFFF};
  logic [QW-1:0] vq [NV] = '{26'h2000000, 26'h3000000, 26'h1555555,
                             26'h3FFFFFC, 26'h1000001, 26'h2000000};
  logic [MW:0]   vr [NV] = '{25'h0, 25'h0, 25'h0800000,
                             25'h0, 25'h0000002, 25'h0};

  // Driver: called on a falling edge; returns on the falling edge of cycle 1.
  task automatic do_start(input logic [MW-1:0] a, input logic [MW-1:0] b);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc is the cycle number in which it was seen.
  task automatic wait_done(input int first_cyc, output int cyc);
    cyc = first_cyc;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (bus.done !== 1'b1) begin
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, cyc);
      n_err++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", bus.busy); n_err++; end
    n_vec++; if (bus.done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", bus.done); n_err++; end
    n_vec++; if (bus.q !== '0) begin $display("FAIL reset_q: got %h want 0", bus.q); n_err++; end
    n_vec++; if (bus.rem !== '0) begin $display("FAIL reset_rem: got %h want 0", bus.rem); n_err++; end
    n_vec++; if (bus.dz !== 1'b0) begin $display("FAIL reset_dz: got %b want 0", bus.dz); n_err++; end
    n_vec++; if (dbg_state !== 2'd0) begin $display("FAIL reset_state: got %0d want 0", dbg_state); n_err++; end
`ifdef MANT_DIV_STICKY_EN
    n_vec++; if (bus.sticky !== 1'b0) begin $display("FAIL reset_sticky: got %b want 0", bus.sticky); n_err++; end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divide();
    int cyc;
    for (int i = 0; i < NV; i++) begin
      do_start(va[i], vb[i]);
      n_vec++; if (bus.busy !== 1'b1) begin $display("FAIL div%0d_busy: got %b want 1", i, bus.busy); n_err++; end
      wait_done(1, cyc);
      n_vec++; if (cyc != LAT) begin $display("FAIL div%0d_latency: got %0d want %0d", i, cyc, LAT); n_err++; end
      n_vec++; if (bus.q !== vq[i]) begin $display("FAIL div%0d_q: got %h want %h", i, bus.q, vq[i]); n_err++; end
      n_vec++; if (bus.rem !== vr[i]) begin $display("FAIL div%0d_rem: got %h want %h", i, bus.rem, vr[i]); n_err++; end
      n_vec++; if (bus.dz !== 1'b0) begin $display("FAIL div%0d_dz: got %b want 0", i, bus.dz); n_err++; end
      n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL div%0d_busy_done: got %b want 0", i, bus.busy); n_err++; end
`ifdef MANT_DIV_STICKY_EN
      n_vec++; if (bus.sticky !== (vr[i] != '0)) begin $display("FAIL div%0d_sticky: got %b want %b", i, bus.sticky, vr[i] != '0); n_err++; end
`endif
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b0) begin $display("FAIL div%0d_done_pulse: got %b want 0", i, bus.done); n_err++; end
      n_vec++; if (bus.q !== vq[i]) begin $display("FAIL div%0d_q_hold: got %h want %h", i, bus.q, vq[i]); n_err++; end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_start(24'hFFFFFF, 24'h800000);
    wait_done(1, cyc);
    n_vec++; if (bus.q !== 26'h3FFFFFC) begin $display("FAIL b2b_first_q: got %h want 3fffffc", bus.q); n_err++; end
    // New request raised in the DONE cycle itself.
    do_start(24'h800000, 24'hC00000);
    n_vec++; if (bus.busy !== 1'b1) begin $display("FAIL b2b_busy: got %b want 1", bus.busy); n_err++; end
    n_vec++; if (bus.done !== 1'b0) begin $display("FAIL b2b_done_drop: got %b want 0", bus.done); n_err++; end
    n_vec++; if (bus.q !== '0) begin $display("FAIL b2b_q_clear: got %h want 0", bus.q); n_err++; end
    wait_done(1, cyc);
    n_vec++; if (cyc != LAT) begin $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT); n_err++; end
    n_vec++; if (bus.q !== 26'h1555555) begin $display("FAIL b2b_second_q: got %h want 1555555", bus.q); n_err++; end
    n_vec++; if (bus.rem !== 25'h0800000) begin $display("FAIL b2b_second_rem: got %h want 0800000", bus.rem); n_err++; end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    do_start(24'hC00000, 24'h000000);
    n_vec++; if (bus.done !== 1'b1) begin $display("FAIL dz_done: got %b want 1", bus.done); n_err++; end
    n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL dz_busy: got %b want 0", bus.busy); n_err++; end
    n_vec++; if (bus.q !== 26'h3FFFFFF) begin $display("FAIL dz_q: got %h want 3ffffff", bus.q); n_err++; end
    n_vec++; if (bus.rem !== '0) begin $display("FAIL dz_rem: got %h want 0", bus.rem); n_err++; end
    n_vec++; if (bus.dz !== 1'b1) begin $display("FAIL dz_flag: got %b want 1", bus.dz); n_err++; end
`ifdef MANT_DIV_STICKY_EN
    n_vec++; if (bus.sticky !== 1'b0) begin $display("FAIL dz_sticky: got %b want 0", bus.sticky); n_err++; end
`endif
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0) begin $display("FAIL dz_done_pulse: got %b want 0", bus.done); n_err++; end
    n_vec++; if (bus.dz !== 1'b1) begin $display("FAIL dz_hold: got %b want 1", bus.dz); n_err++; end
    n_vec++; if (dbg_state !== 2'd0) begin $display("FAIL dz_state_idle: got %0d want 0", dbg_state); n_err++; end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    do_start(24'hC00000, 24'h800000);
    n_vec++; if (bus.dz !== 1'b0) begin $display("FAIL ign_dz_clear: got %b want 0", bus.dz); n_err++; end
    repeat (5) @(negedge clk);
    do_start(24'hFFFFFF, 24'h000000);
    repeat (3) @(negedge clk);
    do_start(24'h800000, 24'hC00000);
    n_vec++; if (bus.busy !== 1'b1) begin $display("FAIL ign_busy: got %b want 1", bus.busy); n_err++; end
    wait_done(11, cyc);
    n_vec++; if (cyc != LAT) begin $display("FAIL ign_latency: got %0d want %0d", cyc, LAT); n_err++; end
    n_vec++; if (bus.q !== 26'h3000000) begin $display("FAIL ign_q: got %h want 3000000", bus.q); n_err++; end
    n_vec++; if (bus.dz !== 1'b0) begin $display("FAIL ign_dz: got %b want 0", bus.dz); n_err++; end
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL ign_idle: got %b want 0", bus.busy); n_err++; end
  endtask

  task automatic test_reset_mid_run();
    int  cyc;
    logic seen_done;
    do_start(24'h800000, 24'hC00000);
    repeat (9) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b1) begin $display("FAIL abort_busy_before: got %b want 1", bus.busy); n_err++; end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL abort_busy: got %b want 0", bus.busy); n_err++; end
    n_vec++; if (bus.done !== 1'b0) begin $display("FAIL abort_done: got %b want 0", bus.done); n_err++; end
    n_vec++; if (bus.q !== '0) begin $display("FAIL abort_q: got %h want 0", bus.q); n_err++; end
    n_vec++; if (dbg_state !== 2'd0) begin $display("FAIL abort_state: got %0d want 0", dbg_state); n_err++; end
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    n_vec++; if (seen_done !== 1'b0) begin $display("FAIL abort_no_done: got %b want 0", seen_done); n_err++; end
    do_start(24'h800000, 24'h800000);
    wait_done(1, cyc);
    n_vec++; if (cyc != LAT) begin $display("FAIL abort_rerun_latency: got %0d want %0d", cyc, LAT); n_err++; end
    n_vec++; if (bus.q !== 26'h2000000) begin $display("FAIL abort_rerun_q: got %h want 2000000", bus.q); n_err++; end
    n_vec++; if (bus.rem !== '0) begin $display("FAIL abort_rerun_rem: got %h want 0", bus.rem); n_err++; end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_back_to_back();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
